rotation_slot_tracker: RTL
==========================

Name: rotation_slot_tracker

Overview:
- Sits upstream of frame_manager and hub75_output, in place of the trip-to-angle stage.
- Measures the rotation period from successive rising edges of the debounced IR-trip signal.
- Divides each rotation into ROTATIONAL_RES equal angular slots using a division-free phase accumulator.
- Presents the current slot index, a per-slot tick and validity flags to the frame pipeline.

Parameters:
- ROTATIONAL_RES, 1024: slots per revolution; power of two.
- PERIOD_W, 24: width of the period counter and register. At 24 MHz this covers about 0.7 s per revolution.
- MIN_PERIOD, 4096: edges closer than this many cycles are rejected as glitches. Must be ≥ ROTATIONAL_RES.

Ports:
- clk_in  input  1  system clock (sysclk domain).
- rst_in  input  1  asynchronous, active-low reset.
- ir_tripped  input  1  debounced IR level, synchronous to clk_in.
- dtheta  output  $clog2(ROTATIONAL_RES)  current angular slot, 0 at the IR edge.
- dtheta_valid  output  1  high only in TRACK state.
- slot_tick  output  1  one-cycle pulse whenever dtheta changes, including the reset to 0 on an edge in TRACK.
- period_out  output  PERIOD_W  last accepted period in cycles.
- period_valid  output  1  period_out holds a measured value.
- stalled  output  1  sticky; set on period timeout, cleared by the next accepted edge.

Behaviour:
- Reset (rst_in low, async): all outputs 0; state IDLE; period_cnt=0; acc=0; ir_q=0.
- Edge detect: rise = ir_tripped & ~ir_q, with ir_q registered every cycle.
- Accepted edge: rise while (state==IDLE or period_cnt ≥ MIN_PERIOD). A rise with period_cnt < MIN_PERIOD outside IDLE is ignored, and counting continues uninterrupted.
- period_cnt: increments every cycle outside IDLE and saturates at 2^PERIOD_W−1. On an accepted edge it loads 1, so edges N cycles apart measure exactly N.
- State IDLE:
  - Accepted edge → ACQUIRE; period_cnt<=1.
  - dtheta_valid=0.
- State ACQUIRE:
  - Accepted edge → TRACK; period_reg<=period_cnt; period_valid<=1; dtheta<=0; acc<=0; slot_tick<=1.
  - Saturation → IDLE; stalled<=1.
- State TRACK:
  - Accepted edge: period_reg<=period_cnt; dtheta<=0; acc<=0; slot_tick<=1; stay in TRACK.
  - Otherwise each cycle: if acc+ROTATIONAL_RES ≥ period_reg, then acc<=acc+ROTATIONAL_RES−period_reg, dtheta++, slot_tick<=1. Else acc<=acc+ROTATIONAL_RES, slot_tick<=0.
  - acc is PERIOD_W+1 bits wide. At most one step per cycle, guaranteed by MIN_PERIOD ≥ ROTATIONAL_RES.
  - Slowdown clamp: dtheta never wraps. At ROTATIONAL_RES−1 it holds and no further slot_tick is issued until the next edge.
  - Saturation → IDLE; dtheta_valid<=0; period_valid<=0; dtheta<=0; stalled<=1.
- Simultaneous accepted edge and saturation in the same cycle: the edge wins and no stall is flagged.
- Simultaneous edge and accumulator step: the edge wins; dtheta=0 and acc=0.
- Latency: dtheta, slot_tick and period_out all update on the clock edge following the cycle in which rise is observed.
- Reset asserted mid-rotation returns to IDLE immediately. The first edge after reset is never used as a period endpoint.

Optional Feature:
- Macro ROTATION_SLOT_PERIOD_AVG_EN.
- When defined: on an accepted edge in TRACK, period_reg<=(period_reg+period_cnt+1)>>1, a rounded 2-tap average that damps jitter. The ACQUIRE→TRACK transition still loads the raw period.
- When undefined: period_reg<=period_cnt raw, every time.

Test Plan (parameters ROTATIONAL_RES=8, PERIOD_W=8, MIN_PERIOD=8 unless noted):
- Reset with ir_tripped toggling → all outputs stay 0 while rst_in=0. After release, the first rise enters ACQUIRE with dtheta_valid=0.
- Rises every 64 cycles → after the 2nd rise: period_out=64, dtheta_valid=1. dtheta steps 0..7, one step every 8 cycles; 8 slot_tick pulses per rotation.
- Rise period then lengthens to 100 after steady 64 → dtheta clamps at 7 for the remainder of that revolution. On the next edge, dtheta=0 and period_out=100.
- Rise 5 cycles after an accepted edge → ignored; period_out unchanged, and the next true rise at 64 measures 64.
- No rise for 255 cycles in TRACK → state IDLE, stalled=1, dtheta_valid=0, period_valid=0. The next two rises restore TRACK and clear stalled.
- With ROTATION_SLOT_PERIOD_AVG_EN: periods 64 then 80 → period_out=72. Without the macro → period_out=80.

Source files
------------

// File: rtl/rotation_slot_tracker.sv
// rotation_slot_tracker: measures the IR-trip rotation period and splits each
// revolution into ROTATIONAL_RES angular slots with a division-free phase
// accumulator. Outputs the current slot, a per-slot tick and validity flags.
// Optional build macro ROTATION_SLOT_PERIOD_AVG_EN: in TRACK, each accepted
// edge loads a rounded 2-tap average of the old and new period instead of the
// raw measurement.
module rotation_slot_tracker #(
    parameter int ROTATIONAL_RES = 1024,
    parameter int PERIOD_W       = 24,
    parameter int MIN_PERIOD     = 4096
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              ir_tripped,
    output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    output logic                              dtheta_valid,
    output logic                              slot_tick,
    output logic [PERIOD_W-1:0]               period_out,
    output logic                              period_valid,
    output logic                              stalled
);

    localparam int DW = $clog2(ROTATIONAL_RES);

    localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
    localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W:0]   RES_A     = (PERIOD_W+1)'(ROTATIONAL_RES);
    localparam logic [DW-1:0]       SLOT_LAST = DW'(ROTATIONAL_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_TRACK   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ir_q, ir_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [PERIOD_W:0]   acc_q, acc_d;
    logic [PERIOD_W-1:0] period_reg_q, period_reg_d;
    logic [DW-1:0]       dtheta_q, dtheta_d;
    logic                slot_tick_q, slot_tick_d;
    logic                period_valid_q, period_valid_d;
    logic                stalled_q, stalled_d;

    logic                rise;
    logic                accept;
    logic                cnt_sat;
    logic [PERIOD_W:0]   acc_sum;
    logic                step;
    logic [PERIOD_W-1:0] track_period;

    assign rise    = ir_tripped & ~ir_q;
    assign cnt_sat = (period_cnt_q == CNT_MAX);
    // Edges too close to the previous one are glitches, except from IDLE
    // where no rotation is being timed yet.
    assign accept  = rise & ((state_q == S_IDLE) | (period_cnt_q >= MIN_P));
    // acc < period_reg always holds, so acc + RES fits in PERIOD_W+1 bits.
    assign acc_sum = acc_q + RES_A;
    assign step    = (acc_sum >= {1'b0, period_reg_q});

`ifdef ROTATION_SLOT_PERIOD_AVG_EN
    logic [PERIOD_W:0] avg_sum;
    // Rounded mean of the previous and newly measured period.
    assign avg_sum      = {1'b0, period_reg_q} + {1'b0, period_cnt_q} + (PERIOD_W+1)'(1);
    assign track_period = PERIOD_W'(avg_sum >> 1);
`else
    assign track_period = period_cnt_q;
`endif

    // Next-state, period counting and phase accumulator stepping.
    always_comb begin
        state_d        = state_q;
        ir_d           = ir_tripped;
        period_cnt_d   = period_cnt_q;
        acc_d          = acc_q;
        period_reg_d   = period_reg_q;
        dtheta_d       = dtheta_q;
        slot_tick_d    = 1'b0;
        period_valid_d = period_valid_q;
        stalled_d      = stalled_q;

        if (state_q != S_IDLE && !cnt_sat)
            period_cnt_d = period_cnt_q + PERIOD_W'(1);

        if (accept) begin
            period_cnt_d = PERIOD_W'(1);
            stalled_d    = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = S_ACQUIRE;
            end
            S_ACQUIRE: begin
                // First full period: always the raw measurement.
                if (accept) begin
                    state_d        = S_TRACK;
                    period_reg_d   = period_cnt_q;
                    period_valid_d = 1'b1;
                    dtheta_d       = '0;
                    acc_d          = '0;
                    slot_tick_d    = 1'b1;
                end else if (cnt_sat) begin
                    state_d      = S_IDLE;
                    stalled_d    = 1'b1;
                    period_cnt_d = '0;
                end
            end
            S_TRACK: begin
                // An edge beats both a timeout and a pending slot step.
                if (accept) begin
                    period_reg_d = track_period;
                    dtheta_d     = '0;
                    acc_d        = '0;
                    slot_tick_d  = 1'b1;
                end else if (cnt_sat) begin
                    state_d        = S_IDLE;
                    period_valid_d = 1'b0;
                    dtheta_d       = '0;
                    acc_d          = '0;
                    stalled_d      = 1'b1;
                    period_cnt_d   = '0;
                end else if (step) begin
                    acc_d = acc_sum - {1'b0, period_reg_q};
                    // Clamp at the last slot when the wheel slows down.
                    if (dtheta_q != SLOT_LAST) begin
                        dtheta_d    = dtheta_q + DW'(1);
                        slot_tick_d = 1'b1;
                    end
                end else begin
                    acc_d = acc_sum;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= S_IDLE;
            ir_q           <= 1'b0;
            period_cnt_q   <= '0;
            acc_q          <= '0;
            period_reg_q   <= '0;
            dtheta_q       <= '0;
            slot_tick_q    <= 1'b0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ir_q           <= ir_d;
            period_cnt_q   <= period_cnt_d;
            acc_q          <= acc_d;
            period_reg_q   <= period_reg_d;
            dtheta_q       <= dtheta_d;
            slot_tick_q    <= slot_tick_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
        end
    end

    assign dtheta       = dtheta_q;
    assign dtheta_valid = (state_q == S_TRACK);
    assign slot_tick    = slot_tick_q;
    assign period_out   = period_reg_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;

endmodule
